fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Consumer-side controller for the team's prefetch FIFO read port (rd_en/rd_vld/rd_data).
- On a start request it pops exactly burst_len words from the FIFO.
- Each word is forwarded through a registered valid/ready stream with start-of-packet and end-of-packet markers.
- Sits between a line/frame FIFO and a burst-oriented sink (DDR write master, video line packer).

Parameters:
DATA_WIDTH, 16, FIFO and stream data width
LEN_WIDTH, 12, width of burst length and word counter (max burst 2^LEN_WIDTH-1 words)
TIMEOUT_CYC, 1024, stall limit in cycles (used only with FIFO_RD_TIMEOUT_EN)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-low reset
start  in  1  burst request; sampled only in IDLE
burst_len  in  LEN_WIDTH  words to transfer; captured with start
busy  out  1  high from accepted start until done pulse, inclusive
done  out  1  one-cycle pulse at burst completion
err  out  1  timeout flag, valid with done (tied 0 without macro)
word_cnt  out  LEN_WIDTH  words accepted by sink in current/last burst
fifo_rd_en  out  1  pop strobe to prefetch FIFO
fifo_rd_vld  in  1  FIFO head word valid
fifo_rd_data  in  DATA_WIDTH  FIFO head word
m_valid  out  1  stream data valid
m_ready  in  1  sink ready
m_data  out  DATA_WIDTH  stream data
m_sop  out  1  first word of burst, qualified by m_valid
m_eop  out  1  last word of burst, qualified by m_valid

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; internal remaining count 0.
- States: IDLE, BURST, DRAIN, DONE.
- IDLE:
  - start=1 with burst_len>0: latch the length into the remaining count, clear word_cnt, go to BURST, busy=1 next cycle.
  - start=1 with burst_len=0: go directly to DONE; no stream words; word_cnt=0.
  - start outside IDLE is ignored.
- Pop rule (combinational): fifo_rd_en = (state==BURST) & fifo_rd_vld & (remaining!=0) & (!m_valid | m_ready).
  - Never assert fifo_rd_en when fifo_rd_vld=0.
- On a pop:
  - m_data <= fifo_rd_data, m_valid <= 1, remaining decrements.
  - m_sop <= (first pop of burst).
  - m_eop <= (remaining==1).
  - Latency from pop to m_valid is 1 cycle.
- Output register:
  - m_valid clears when m_ready=1 and no new pop in the same cycle.
  - m_data/m_sop/m_eop hold stable while m_valid=1 and m_ready=0.
- Full throughput: with fifo_rd_vld=1 and m_ready=1 continuously, one word per cycle.
- A burst of 1 word: m_sop and m_eop both set on the same word.
- word_cnt increments on each m_valid & m_ready handshake and saturates at burst_len.
- BURST -> DRAIN: when the last pop occurs (remaining 1 -> 0).
- DRAIN -> DONE: when m_valid & m_ready & m_eop.
- DONE:
  - done=1 for one cycle, busy still 1.
  - Next state IDLE; busy=0 the following cycle.
  - start is not sampled in DONE.
- FIFO empty mid-burst (fifo_rd_vld=0): stall in BURST with m_valid cleared once the sink consumes; no bubble words and no markers duplicated.
- Sink backpressure: at most one word is held; no pop until that word is accepted.
- Async reset mid-burst: everything returns to reset values immediately; partial burst is abandoned; FIFO contents untouched.

Optional Feature:
FIFO_RD_TIMEOUT_EN
- Defined:
  - A stall counter increments each BURST cycle with remaining!=0 and fifo_rd_vld=0, and clears on any pop.
  - When the counter reaches TIMEOUT_CYC, the burst is aborted.
  - If a word is held in the output register, it is drained normally; it is not re-marked as eop.
  - State then goes to DONE with done=1 and err=1; word_cnt shows words actually delivered.
  - err returns to 0 on the next accepted start.
- Not defined: no stall counter; BURST waits indefinitely for data; err tied 0.

Test Plan:
- Preload 8 words 0x0001..0x0008; start with burst_len=8; m_ready=1 -> fifo_rd_en high 8 consecutive cycles; m_data 1..8 back-to-back; m_sop on 0x0001; m_eop on 0x0008; done 1 cycle after last handshake; word_cnt=8.
- burst_len=4; m_ready toggled 1,0,0,1,... -> no word lost or duplicated; m_data held during m_ready=0; exactly 4 pops; sequence intact.
- Preload 2 words; burst_len=5; push 3 more words 20 cycles later -> stall with m_valid=0 and no done; then completes with 5 words; m_eop on 5th.
- burst_len=1 -> single word with m_sop=m_eop=1; burst_len=0 -> done 1 cycle later; no m_valid; word_cnt=0.
- Assert rst low mid-burst after 3 of 8 words -> all outputs 0 immediately; a new start of length 5 pops the next 5 FIFO words correctly.
- With FIFO_RD_TIMEOUT_EN and TIMEOUT_CYC=16: burst_len=4, only 2 words available -> done with err=1 after 16 empty cycles; word_cnt=2.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a requested number of words from a prefetch FIFO
// read port and forwards them through a registered valid/ready stream with
// start/end-of-packet markers. The optional stall timeout is compiled in
// when the macro FIFO_RD_TIMEOUT_EN is defined; without it a burst waits for
// data indefinitely and err is tied low.
module fifo_burst_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int LEN_WIDTH   = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  word_cnt,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic [1:0]            state_reg, state_next;
  logic [LEN_WIDTH-1:0]  remaining_reg, len_reg, word_cnt_reg;
  logic                  first_reg;
  logic                  valid_reg, sop_reg, eop_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  accept_start, pop, handshake;
  logic                  timeout_hit, aborted;

  assign accept_start = (state_reg == S_IDLE) && start;
  // A word is popped only when the output register is free or being emptied.
  assign pop = (state_reg == S_BURST) && fifo_rd_vld && (remaining_reg != '0) &&
               (!valid_reg || m_ready);
  assign handshake = valid_reg && m_ready;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_reg;
  logic               err_reg, abort_reg, stalled;

  assign stalled     = (state_reg == S_BURST) && (remaining_reg != '0) && !fifo_rd_vld;
  assign timeout_hit = stalled && (stall_reg == STALL_W'(TIMEOUT_CYC - 1));

  // Count FIFO-empty cycles inside a burst; any pop restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_reg <= '0;
    end else if ((state_reg != S_BURST) || pop) begin
      stall_reg <= '0;
    end else if (stalled) begin
      stall_reg <= stall_reg + 1'b1;
    end
  end

  // Abort/error flags live from the timeout until the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg   <= 1'b0;
      abort_reg <= 1'b0;
    end else if (accept_start) begin
      err_reg   <= 1'b0;
      abort_reg <= 1'b0;
    end else if (timeout_hit) begin
      err_reg   <= 1'b1;
      abort_reg <= 1'b1;
    end
  end

  assign err     = err_reg;
  assign aborted = abort_reg;
`else
  assign timeout_hit = 1'b0;
  assign aborted     = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = (burst_len == '0) ? S_DONE : S_BURST;
      end
      S_BURST: begin
        if (timeout_hit) begin
          // A word still waiting on the sink must drain before finishing.
          state_next = (valid_reg && !m_ready) ? S_DRAIN : S_DONE;
        end else if (pop && (remaining_reg == LEN_WIDTH'(1))) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((handshake && eop_reg) || (aborted && (!valid_reg || m_ready)))
          state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Burst bookkeeping: remaining pops, latched length, delivered-word count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining_reg <= '0;
      len_reg       <= '0;
      word_cnt_reg  <= '0;
      first_reg     <= 1'b0;
    end else if (accept_start) begin
      remaining_reg <= burst_len;
      len_reg       <= burst_len;
      word_cnt_reg  <= '0;
      first_reg     <= 1'b1;
    end else begin
      if (pop) begin
        remaining_reg <= remaining_reg - 1'b1;
        first_reg     <= 1'b0;
      end
      if (handshake && (word_cnt_reg != len_reg))
        word_cnt_reg <= word_cnt_reg + 1'b1;
    end
  end

  // Single-entry output register; holds its word until the sink takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      sop_reg   <= 1'b0;
      eop_reg   <= 1'b0;
    end else if (pop) begin
      valid_reg <= 1'b1;
      data_reg  <= fifo_rd_data;
      sop_reg   <= first_reg;
      eop_reg   <= (remaining_reg == LEN_WIDTH'(1));
    end else if (m_ready) begin
      valid_reg <= 1'b0;
      sop_reg   <= 1'b0;
      eop_reg   <= 1'b0;
    end
  end

  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign word_cnt   = word_cnt_reg;
  assign fifo_rd_en = pop;
  assign m_valid    = valid_reg;
  assign m_data     = data_reg;
  assign m_sop      = sop_reg;
  assign m_eop      = eop_reg;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: a queue-style FIFO model feeds the DUT,
// a negedge monitor records the stream, and each scenario task compares the
// recorded stream with the slice of FIFO words the burst should have taken.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] burst_len;
  logic        busy, done, err;
  logic [11:0] word_cnt;
  logic        fifo_rd_en, fifo_rd_vld;
  logic [15:0] fifo_rd_data;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic        m_sop, m_eop;

  int errors = 0;
  int checks = 0;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int STALL_PUSH_AT = 10;
`else
  localparam int STALL_PUSH_AT = 20;
`endif

  fifo_burst_reader #(.DATA_WIDTH(16), .LEN_WIDTH(12), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sop(m_sop), .m_eop(m_eop)
  );

  always #5 clk = ~clk;

  // FIFO model: linear storage, head at rd_ptr, fifo_en gates availability.
  logic [15:0] fmem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  bit fifo_en = 1'b1;
  assign fifo_rd_vld  = fifo_en && (rd_ptr < wr_ptr);
  assign fifo_rd_data = fmem[rd_ptr[11:0]];
  always @(posedge clk) if (fifo_rd_en && (rd_ptr < wr_ptr)) rd_ptr <= rd_ptr + 1;

  task automatic push(input logic [15:0] v);
    fmem[wr_ptr[11:0]] = v;
    wr_ptr++;
  endtask

  // Monitor state (written only by the monitor process).
  int cyc = 0;
  logic [15:0] got_data[$];
  bit got_sop[$], got_eop[$];
  int hs_cyc[$], pop_cyc[$];
  int pops = 0, dones = 0, done_cyc = -1, start_cyc = -1;
  bit done_busy, done_err;
  logic [11:0] done_wcnt;
  int snap_cyc = -1;
  bit snap_valid, snap_done, snap_busy;
  bit hold_pend = 0;
  logic [15:0] hold_data;
  bit hold_sop, hold_eop;
  int hold_events = 0, hold_bad = 0, rd_bad = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      if (start && !busy) start_cyc = cyc;
      if (fifo_rd_en) begin
        pops++;
        pop_cyc.push_back(cyc);
        if (!fifo_rd_vld) rd_bad++;
      end
      if (hold_pend && !(m_valid && m_data === hold_data &&
                         m_sop === hold_sop && m_eop === hold_eop)) hold_bad++;
      hold_pend = m_valid && !m_ready;
      if (hold_pend) begin
        hold_events++;
        hold_data = m_data; hold_sop = m_sop; hold_eop = m_eop;
      end
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_sop.push_back(m_sop);
        got_eop.push_back(m_eop);
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        dones++; done_cyc = cyc;
        done_busy = busy; done_err = err; done_wcnt = word_cnt;
      end
      if (cyc == snap_cyc) begin
        snap_valid = m_valid; snap_done = done; snap_busy = busy;
      end
    end else begin
      hold_pend = 0;
    end
  end

  // Issues one start and steps the sink/FIFO stimulus until done is seen.
  // rmode: 0 always ready, 1 ready pattern 1,0,0, 2 random. vmode: 0 FIFO
  // always presenting, 2 random availability gaps.
  task automatic run_burst(input int len, input int rmode, input int vmode,
                           input int push_at, input int push_n, input int budget,
                           output bit to, output bit post_busy);
    int d0;
    d0 = dones;
    start = 1'b1;
    burst_len = len[11:0];
    m_ready = 1'b1;
    fifo_en = 1'b1;
    to = 1'b1;
    post_busy = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (dones > d0) begin
        to = 1'b0;
        post_busy = busy;
        break;
      end
      if (k == push_at) for (int j = 0; j < push_n; j++) push(16'($urandom));
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = ((k % 3) == 2);
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      fifo_en = (vmode == 0) ? 1'b1 : ($urandom_range(0, 4) < 3);
    end
    m_ready = 1'b1;
    fifo_en = 1'b1;
    $display("burst len=%0d words_total=%0d pops_total=%0d done_seen=%0d", len,
             got_data.size(), pops, !to);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, word_cnt, fifo_rd_en, m_valid, m_data, m_sop, m_eop} !== '0)
      $display("FAIL reset_outputs got=%h want=0",
               {busy, done, err, word_cnt, fifo_rd_en, m_valid, m_data, m_sop, m_eop});
    if ({busy, done, err, word_cnt, fifo_rd_en, m_valid, m_data, m_sop, m_eop} !== '0) errors++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_full_throughput();
    int b, p0, h0, n;
    bit to, pb;
    b = got_data.size(); p0 = pops; h0 = hs_cyc.size();
    for (int i = 1; i <= 8; i++) push(16'(i));
    run_burst(8, 0, 0, -1, 0, 100, to, pb);
    n = got_data.size() - b;
    checks++; if (to) begin errors++; $display("FAIL ft_done got=none want=done"); end
    checks++; if (n != 8) begin errors++; $display("FAIL ft_count got=%0d want=8", n); end
    for (int i = 0; i < 8 && i < n; i++) begin
      checks++;
      if (got_data[b+i] !== 16'(i + 1) || got_sop[b+i] != (i == 0) || got_eop[b+i] != (i == 7)) begin
        errors++;
        $display("FAIL ft_word%0d got=%h sop=%b eop=%b want=%h", i, got_data[b+i],
                 got_sop[b+i], got_eop[b+i], 16'(i + 1));
      end
    end
    checks++;
    if (pops - p0 != 8 || (pops - p0 == 8 && pop_cyc[p0+7] - pop_cyc[p0] != 7)) begin
      errors++; $display("FAIL ft_pops got=%0d want=8 consecutive", pops - p0);
    end
    if (n == 8) begin
      checks++;
      if (hs_cyc[h0+7] - hs_cyc[h0] != 7) begin
        errors++; $display("FAIL ft_backtoback span=%0d want=7", hs_cyc[h0+7] - hs_cyc[h0]);
      end
      checks++;
      if (done_cyc != hs_cyc[h0+7] + 1) begin
        errors++; $display("FAIL ft_done_latency got=%0d want=%0d", done_cyc, hs_cyc[h0+7] + 1);
      end
    end
    checks++;
    if (done_wcnt !== 12'd8 || done_busy !== 1'b1 || done_err !== 1'b0 || pb !== 1'b0) begin
      errors++;
      $display("FAIL ft_status wcnt=%0d busy=%b err=%b after=%b want 8 1 0 0",
               done_wcnt, done_busy, done_err, pb);
    end
  endtask

  task automatic test_backpressure();
    int b, p0, sr, ev0, n;
    bit to, pb;
    b = got_data.size(); p0 = pops; ev0 = hold_events; sr = rd_ptr;
    for (int i = 0; i < 4; i++) push(16'($urandom));
    run_burst(4, 1, 0, -1, 0, 100, to, pb);
    n = got_data.size() - b;
    checks++; if (to || n != 4) begin errors++; $display("FAIL bp_count got=%0d want=4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (got_data[b+i] !== fmem[sr+i] || got_sop[b+i] != (i == 0) || got_eop[b+i] != (i == 3)) begin
        errors++; $display("FAIL bp_word%0d got=%h want=%h", i, got_data[b+i], fmem[sr+i]);
      end
    end
    checks++; if (pops - p0 != 4) begin errors++; $display("FAIL bp_pops got=%0d want=4", pops - p0); end
    checks++;
    if (hold_events == ev0) begin errors++; $display("FAIL bp_no_hold got=0 want>0 held cycles"); end
    checks++; if (done_wcnt !== 12'd4) begin errors++; $display("FAIL bp_wcnt got=%0d want=4", done_wcnt); end
  endtask

  task automatic test_underflow();
    int b, sr, n;
    bit to, pb;
    b = got_data.size(); sr = rd_ptr;
    push(16'($urandom)); push(16'($urandom));
    snap_cyc = cyc + 8;
    run_burst(5, 0, 0, STALL_PUSH_AT, 3, 200, to, pb);
    n = got_data.size() - b;
    checks++;
    if (snap_valid !== 1'b0 || snap_done !== 1'b0 || snap_busy !== 1'b1) begin
      errors++; $display("FAIL uf_stall valid=%b done=%b busy=%b want 0 0 1", snap_valid, snap_done, snap_busy);
    end
    checks++; if (to || n != 5) begin errors++; $display("FAIL uf_count got=%0d want=5", n); end
    for (int i = 0; i < 5 && i < n; i++) begin
      checks++;
      if (got_data[b+i] !== fmem[sr+i] || got_sop[b+i] != (i == 0) || got_eop[b+i] != (i == 4)) begin
        errors++; $display("FAIL uf_word%0d got=%h eop=%b want=%h", i, got_data[b+i], got_eop[b+i], fmem[sr+i]);
      end
    end
    checks++; if (done_wcnt !== 12'd5) begin errors++; $display("FAIL uf_wcnt got=%0d want=5", done_wcnt); end
  endtask

  task automatic test_short_bursts();
    int b, p0, sr;
    bit to, pb;
    b = got_data.size(); sr = rd_ptr;
    push(16'($urandom));
    run_burst(1, 0, 0, -1, 0, 50, to, pb);
    checks++;
    if (to || got_data.size() - b != 1) begin
      errors++; $display("FAIL one_count got=%0d want=1", got_data.size() - b);
    end else begin
      checks++;
      if (got_data[b] !== fmem[sr] || !got_sop[b] || !got_eop[b] || done_wcnt !== 12'd1) begin
        errors++; $display("FAIL one_word got=%h sop=%b eop=%b wcnt=%0d want=%h 1 1 1",
                           got_data[b], got_sop[b], got_eop[b], done_wcnt, fmem[sr]);
      end
    end
    b = got_data.size(); p0 = pops;
    push(16'($urandom));
    run_burst(0, 0, 0, -1, 0, 50, to, pb);
    checks++;
    if (to || done_cyc != start_cyc + 1) begin
      errors++; $display("FAIL zero_latency got=%0d want=%0d", done_cyc - start_cyc, 1);
    end
    checks++;
    if (got_data.size() != b || pops != p0 || done_wcnt !== 12'd0) begin
      errors++; $display("FAIL zero_words got=%0d pops=%0d wcnt=%0d want 0 0 0",
                         got_data.size() - b, pops - p0, done_wcnt);
    end
    checks++;
    if (done_busy !== 1'b1 || pb !== 1'b0) begin
      errors++; $display("FAIL zero_busy during=%b after=%b want 1 0", done_busy, pb);
    end
  endtask

  task automatic test_reset_mid_burst();
    int b, sr, sr2, rp, n;
    bit to, pb, got3;
    b = got_data.size(); sr = rd_ptr;
    for (int i = 0; i < 8; i++) push(16'($urandom));
    start = 1'b1; burst_len = 12'd8; m_ready = 1'b1; fifo_en = 1'b1;
    got3 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (got_data.size() - b >= 3) begin got3 = 1'b1; break; end
    end
    checks++; if (!got3) begin errors++; $display("FAIL rmb_progress got=%0d want=3", got_data.size() - b); end
    for (int i = 0; i < 3 && i < got_data.size() - b; i++) begin
      checks++;
      if (got_data[b+i] !== fmem[sr+i]) begin
        errors++; $display("FAIL rmb_partial%0d got=%h want=%h", i, got_data[b+i], fmem[sr+i]);
      end
    end
    rst = 1'b0;
    #1;
    rp = rd_ptr;
    checks++;
    if ({busy, done, err, word_cnt, fifo_rd_en, m_valid, m_data, m_sop, m_eop} !== '0) begin
      errors++;
      $display("FAIL rmb_async_clear got=%h want=0",
               {busy, done, err, word_cnt, fifo_rd_en, m_valid, m_data, m_sop, m_eop});
    end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (rd_ptr != rp) begin errors++; $display("FAIL rmb_fifo_touched got=%0d want=%0d", rd_ptr, rp); end
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push(16'($urandom));
    b = got_data.size(); sr2 = rd_ptr;
    run_burst(5, 0, 0, -1, 0, 100, to, pb);
    n = got_data.size() - b;
    checks++; if (to || n != 5) begin errors++; $display("FAIL rmb_restart_count got=%0d want=5", n); end
    for (int i = 0; i < 5 && i < n; i++) begin
      checks++;
      if (got_data[b+i] !== fmem[sr2+i] || got_sop[b+i] != (i == 0) || got_eop[b+i] != (i == 4)) begin
        errors++; $display("FAIL rmb_restart%0d got=%h want=%h", i, got_data[b+i], fmem[sr2+i]);
      end
    end
  endtask

  task automatic test_random();
    int len, b, p0, sr, n;
    bit to, pb;
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(0, 24);
      b = got_data.size(); p0 = pops; sr = rd_ptr;
      for (int i = 0; i < len; i++) push(16'($urandom));
      run_burst(len, 2, 2, -1, 0, 600, to, pb);
      n = got_data.size() - b;
      checks++;
      if (to || n != len || pops - p0 != len || done_wcnt !== 12'(len) || done_err !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_summary words=%0d pops=%0d wcnt=%0d err=%b want len=%0d err=0",
                 t, n, pops - p0, done_wcnt, done_err, len);
      end
      for (int i = 0; i < len && i < n; i++) begin
        checks++;
        if (got_data[b+i] !== fmem[sr+i] || got_sop[b+i] != (i == 0) ||
            got_eop[b+i] != (i == len - 1)) begin
          errors++;
          $display("FAIL rnd%0d_word%0d got=%h sop=%b eop=%b want=%h", t, i, got_data[b+i],
                   got_sop[b+i], got_eop[b+i], fmem[sr+i]);
        end
      end
    end
  endtask

`ifdef FIFO_RD_TIMEOUT_EN
  task automatic test_timeout();
    int b, sr, n;
    bit to, pb;
    b = got_data.size(); sr = rd_ptr;
    push(16'($urandom)); push(16'($urandom));
    run_burst(4, 0, 0, -1, 0, 200, to, pb);
    n = got_data.size() - b;
    checks++;
    if (to || done_err !== 1'b1 || done_wcnt !== 12'd2) begin
      errors++; $display("FAIL to_abort err=%b wcnt=%0d want 1 2", done_err, done_wcnt);
    end
    checks++;
    if (n != 2 || (n == 2 && (got_data[b+1] !== fmem[sr+1] || got_eop[b+1]))) begin
      errors++; $display("FAIL to_words got=%0d want=2 without eop", n);
    end
    push(16'($urandom));
    run_burst(1, 0, 0, -1, 0, 50, to, pb);
    checks++;
    if (to || done_err !== 1'b0) begin errors++; $display("FAIL to_err_clear got=%b want=0", done_err); end
  endtask
`endif

  task automatic test_stream_rules();
    checks++; if (rd_bad != 0) begin errors++; $display("FAIL rd_en_without_vld got=%0d want=0", rd_bad); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL held_word_changed got=%0d want=0", hold_bad); end
  endtask

  initial begin
    test_reset();
    test_full_throughput();
    test_backpressure();
    test_underflow();
    test_short_bursts();
    test_reset_mid_burst();
    test_random();
`ifdef FIFO_RD_TIMEOUT_EN
    test_timeout();
`endif
    test_stream_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
